// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg
// Shared types and helpers for the shared-register arbiter family.
//   state_t  : sequencer states (IDLE, GRANT, WRITE)
//   DEF_*    : default requester count and data width
//   rr_pick  : rotate-priority search helper used by rr_priority_pick
// Optional feature macro used by the arbiter: REGARB_LOCK_EN.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int MAX_REQ    = 8;

  // Returns {any_req, index[2:0]}: first set bit of req[n-1:0] found by
  // searching upward from ptr and wrapping from n-1 back to 0.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int n,
                                         input logic [2:0] ptr);
    logic [3:0] res;
    int         s;
    res = 4'b0000;
    for (int k = 0; k < MAX_REQ; k++) begin
      if ((k < n) && !res[3]) begin
        s = int'(ptr) + k;
        if (s >= n) begin
          s = s - n;
        end else begin
          s = s;
        end
        if (req[3'(s)]) begin
          res = {1'b1, 3'(s)};
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
// Bus between the requesters and the shared-register arbiter.
//   req     : per-requester write request (level, held until ack)
//   wdata   : write-data lanes, lane i = wdata[i*DATA_W +: DATA_W]
//   lock    : per-requester ownership lock (only with REGARB_LOCK_EN)
//   grant   : one-hot grant from the arbiter
//   ack     : one-hot single-cycle write-complete pulse
//   q       : shared register contents
//   q_valid : q holds written data
//   owner   : index of last writer
//   busy    : arbiter not idle
// Modports: master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wdata;
`ifdef REGARB_LOCK_EN
  logic [N_REQ-1:0]        lock;
`endif
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       q;
  logic                    q_valid;
  logic [IDX_W-1:0]        owner;
  logic                    busy;

`ifdef REGARB_LOCK_EN
  modport master (output req, wdata, lock,
                  input  grant, ack, q, q_valid, owner, busy);
  modport slave  (input  req, wdata, lock,
                  output grant, ack, q, q_valid, owner, busy);
`else
  modport master (output req, wdata,
                  input  grant, ack, q, q_valid, owner, busy);
  modport slave  (input  req, wdata,
                  output grant, ack, q, q_valid, owner, busy);
`endif

endinterface

// File: rtl/shared_reg_arbiter_pick.sv
// rr_priority_pick
// Combinational rotating-priority picker.
//   req     : request vector
//   rr_ptr  : index holding highest priority
//   winner  : first requesting index at or above rr_ptr (wrapping)
//   any_req : at least one request present (winner is meaningful)
module rr_priority_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [MAX_REQ-1:0] req_ext_s;
  logic [3:0]         pick_s;
  logic               unused_s;

  // Widen the request vector to the helper's fixed width and run the search
  always_comb begin
    req_ext_s              = '0;
    req_ext_s[N_REQ-1:0]   = req;
    pick_s                 = rr_pick(req_ext_s, N_REQ, 3'(rr_ptr));
  end

  assign winner   = pick_s[IDX_W-1:0];
  assign any_req  = pick_s[3];
  // Upper index bits are always zero for small N_REQ.
  assign unused_s = ^pick_s;

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin arbiter and write sequencer owning one shared D register.
// A winner is picked in IDLE, granted for one cycle, and its lane is
// written with a one-cycle ack if it still requests; otherwise the grant
// is abandoned with no write. The just-served requester drops to lowest
// priority for the next arbitration.
//   clk   : rising-edge clock
//   reset : asynchronous reset, active low
//   bus   : shared_reg_arbiter_if.slave (req/wdata in; grant/ack/q/
//           q_valid/owner/busy out)
// Optional feature macro: REGARB_LOCK_EN -- a locked, still-requesting
// owner is re-granted straight from WRITE without re-arbitration.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter  int N_REQ  = DEF_N_REQ,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus
);

  localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t             state_r, state_n;
  logic [N_REQ-1:0]   grant_r, grant_n;
  logic [N_REQ-1:0]   ack_r, ack_n;
  logic [DATA_W-1:0]  q_r, q_n;
  logic               q_valid_r, q_valid_n;
  logic [IDX_W-1:0]   owner_r, owner_n;
  logic [IDX_W-1:0]   winner_r, winner_n;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_n;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic               any_req_s;
  logic               hold_s;
  logic [N_REQ-1:0]   pick_onehot_s;
  logic [N_REQ-1:0]   win_onehot_s;
  logic [DATA_W-1:0]  lane_s;

  rr_priority_pick #(
    .N_REQ   (N_REQ)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_r),
    .winner  (pick_s),
    .any_req (any_req_s)
  );

  assign pick_onehot_s = ONE_HOT_LSB << pick_s;
  assign win_onehot_s  = ONE_HOT_LSB << winner_r;
  assign lane_s        = bus.wdata[int'(winner_r) * DATA_W +: DATA_W];
  // The pointer moves just past the writer, so it loses priority next time.
  assign next_ptr_s    = (winner_r == IDX_W'(N_REQ - 1)) ? '0 : winner_r + IDX_W'(1);

`ifdef REGARB_LOCK_EN
  assign hold_s = bus.lock[winner_r] & bus.req[winner_r];
`else
  assign hold_s = 1'b0;
`endif

  // Next-state and next-output decode of the grant/write sequence
  always_comb begin
    state_n   = state_r;
    grant_n   = '0;
    ack_n     = '0;
    q_n       = q_r;
    q_valid_n = q_valid_r;
    owner_n   = owner_r;
    winner_n  = winner_r;
    rr_ptr_n  = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          winner_n = pick_s;
          grant_n  = pick_onehot_s;
          state_n  = GRANT;
        end else begin
          state_n  = IDLE;
        end
      end
      GRANT: begin
        // A winner that withdrew is dropped: no write, pointer untouched.
        if (bus.req[winner_r]) begin
          q_n       = lane_s;
          q_valid_n = 1'b1;
          owner_n   = winner_r;
          ack_n     = win_onehot_s;
          state_n   = WRITE;
        end else begin
          state_n   = IDLE;
        end
      end
      WRITE: begin
        if (hold_s) begin
          grant_n  = win_onehot_s;
          state_n  = GRANT;
        end else begin
          rr_ptr_n = next_ptr_s;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      ack_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
      winner_r  <= '0;
      rr_ptr_r  <= '0;
    end else begin
      state_r   <= state_n;
      grant_r   <= grant_n;
      ack_r     <= ack_n;
      q_r       <= q_n;
      q_valid_r <= q_valid_n;
      owner_r   <= owner_n;
      winner_r  <= winner_n;
      rr_ptr_r  <= rr_ptr_n;
    end
  end

  assign bus.grant   = grant_r;
  assign bus.ack     = ack_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;
  assign bus.busy    = (state_r != IDLE);

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter and write sequencer that shares one rising-edge D register bank between N_REQ requesters. Each requester presents data and a request. The block grants one requester at a time, captures its data into the shared register, and returns a one-cycle acknowledge. It sits in front of the flip-flop datapath as its sole write controller.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, width of the shared register and of each write-data lane
IDX_W, $clog2(N_REQ), width of the owner index (derived, not overridden)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
req  input  N_REQ  per-requester write request; level, held until ack
wdata  input  N_REQ*DATA_W  write data; lane i = bits [i*DATA_W +: DATA_W]; must be stable while req[i] is high
grant  output  N_REQ  registered one-hot grant; all zeros when no grant
ack  output  N_REQ  registered one-hot, single-cycle write-complete pulse
q  output  DATA_W  shared register contents
q_valid  output  1  high once q holds written data; cleared only by reset
owner  output  IDX_W  index of the last requester that wrote q
busy  output  1  high while state != IDLE

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE, grant = 0, ack = 0, q = 0, q_valid = 0, owner = 0, rr_ptr = 0. Takes effect immediately, including mid-transaction; the in-flight write is discarded with no ack.
- FSM states: IDLE, GRANT, WRITE.
- IDLE:
  - If req != 0, pick the winner: the first set req bit searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
  - Next edge: grant = onehot(winner), state = GRANT.
  - If req == 0, remain in IDLE.
- GRANT:
  - If req[winner] is still 1 at the edge: q = wdata lane winner, q_valid = 1, owner = winner, ack = onehot(winner), grant = 0, state = WRITE.
  - If req[winner] has dropped: abort. grant = 0, state = IDLE, q and rr_ptr unchanged, no ack.
- WRITE: next edge: ack = 0, rr_ptr = (winner + 1) mod N_REQ, state = IDLE.
- Latency: req sampled high at edge E gives grant at E+1, q/ack at E+2, and IDLE at E+3. Maximum throughput is one write per 3 cycles.
- Requester rule: deassert req no later than the edge after seeing ack. If req is still high in the following IDLE, it is re-arbitrated as a new request.
- Fairness: a requester that has just written has lowest priority in the next arbitration. No requester waits more than N_REQ transactions.
- Requests from non-winners that arrive during GRANT or WRITE are ignored until the next IDLE.
- busy = (state != IDLE), decoded from registered state.
- At most one bit set in grant and in ack at any time. grant and ack are never high in the same cycle.

Optional Feature:
Macro: REGARB_LOCK_EN.
- Defined:
  - Adds input lock [N_REQ].
  - In WRITE, if lock[winner] == 1 and req[winner] == 1, the next state is GRANT with the same winner: grant = onehot(winner), rr_ptr is not advanced, ack = 0.
  - This allows back-to-back writes from one owner at one write per 2 cycles.
  - The lock is released when lock[winner] or req[winner] is 0 in WRITE, which then follows the normal path.
- Undefined: no lock port; WRITE always returns to IDLE.

Decomposition:
- Package shared_reg_arbiter_pkg holds:
  - the state enum (IDLE, GRANT, WRITE);
  - default N_REQ/DATA_W constants;
  - the rotate-priority helper function.
- One natural sub-module: rr_priority_pick. It is combinational and takes req, rr_ptr → winner index + any_req. It is reused by future arbiters in the datapath.

Test Plan:
1. Reset = 0 mid-GRANT with req=4'b0010 → grant, ack, q, q_valid, owner all zero in the same cycle; after release, no ack for the aborted request.
2. Single req[2]=1, wdata lane2=8'hA5 at edge E → grant=4'b0100 at E+1, q=8'hA5, ack=4'b0100, owner=2, q_valid=1 at E+2, busy=0 at E+3.
3. req=4'b1111 held continuously, lanes 8'h10/8'h11/8'h12/8'h13 → owners in order 0,1,2,3,0; one ack every 3 cycles.
4. rr_ptr=3 (after owner 2), req=4'b0101 → wraps and grants requester 0, then requester 2.
5. Abort: req[1] dropped in the GRANT cycle → no ack, q unchanged, rr_ptr unchanged; the next req[1] is granted first.
6. With REGARB_LOCK_EN: lock[3]=1, req[3]=1, req[0]=1, data 8'h01,8'h02,8'h03 → three writes by owner 3, 2 cycles apart, then requester 0 is granted after lock[3] drops.
